// File: rtl/data_write_buffer_pkg.sv
// Shared types for the data-side write buffer: FSM encoding, access sizes
// and the layout of one buffered store.
package data_write_buffer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_ADDR = 3'd1,
        W_DATA = 3'd2,
        R_ADDR = 3'd3,
        R_DATA = 3'd4
    } wb_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } wb_entry_t;

endpackage

// File: rtl/data_write_buffer_fifo.sv
// Store FIFO for the write buffer. The head entry is visible combinationally
// so the drain FSM can present it downstream without an extra cycle.
module wb_fifo
    import data_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  wb_entry_t        push_entry,
    output wb_entry_t        head,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_entry;
    end

    assign head  = mem[rptr];
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/data_write_buffer.sv
// Write-through store buffer: absorbs D-cache stores into a FIFO, drains them
// downstream one at a time, and only lets reads through once fully drained.
module data_write_buffer
    import data_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        up_req,
    input  logic        up_wr,
    input  logic [1:0]  up_size,
    input  logic [31:0] up_addr,
    input  logic [31:0] up_wdata,
    output logic [31:0] up_rdata,
    output logic        up_addr_ok,
    output logic        up_data_ok,
    output logic        dn_req,
    output logic        dn_wr,
    output logic [1:0]  dn_size,
    output logic [31:0] dn_addr,
    output logic [31:0] dn_wdata,
    input  logic [31:0] dn_rdata,
    input  logic        dn_addr_ok,
    input  logic        dn_data_ok,
    output logic        wb_empty
);

    wb_state_e      state, state_next;
    wb_entry_t      head;
    logic           full, empty;
    logic [PTR_W:0] count;
    logic           wr_accept, rd_accept, pop;
    logic           ack_q;
    logic [31:0]    rd_addr;
    logic [1:0]     rd_size;

    // Write acceptance looks only at the registered count, never at dn_*.
    assign wr_accept = up_req & up_wr & ~full;
    assign rd_accept = (state == IDLE) & empty & up_req & ~up_wr;
    assign pop       = (state == W_DATA) & dn_data_ok;

    wb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (wr_accept),
        .pop        (pop),
        .push_entry ({up_addr, up_size, up_wdata}),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            ack_q   <= 1'b0;
            rd_addr <= '0;
            rd_size <= SZ_BYTE;
        end else begin
            state <= state_next;
            ack_q <= wr_accept;
            if (rd_accept) begin
                rd_addr <= up_addr;
                rd_size <= up_size;
            end
        end
    end

    always_comb begin
        state_next = state;
        dn_req     = 1'b0;
        dn_wr      = 1'b0;
        dn_size    = SZ_BYTE;
        dn_addr    = '0;
        dn_wdata   = '0;
        up_rdata   = '0;
        case (state)
            IDLE: begin
                if (!empty)         state_next = W_ADDR;
                else if (rd_accept) state_next = R_ADDR;
            end
            W_ADDR: begin
                dn_req   = 1'b1;
                dn_wr    = 1'b1;
                dn_addr  = head.addr;
                dn_size  = head.size;
                dn_wdata = head.wdata;
                if (dn_addr_ok) state_next = W_DATA;
            end
            W_DATA: begin
                // A push landing on the last pop keeps the drain going.
                if (dn_data_ok)
                    state_next = ((count > (PTR_W+1)'(1)) || wr_accept) ? W_ADDR : IDLE;
            end
            R_ADDR: begin
                dn_req  = 1'b1;
                dn_addr = rd_addr;
                dn_size = rd_size;
                if (dn_addr_ok) state_next = R_DATA;
            end
            R_DATA: begin
                up_rdata = dn_rdata;
                if (dn_data_ok) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign up_addr_ok = wr_accept | rd_accept;
    assign up_data_ok = ack_q | ((state == R_DATA) & dn_data_ok);
    assign wb_empty   = empty & (state == IDLE);

endmodule

// File: tb/tb_data_write_buffer.sv
// Self-checking bench for data_write_buffer: a downstream responder plus a
// scoreboard of expected downstream transactions checked at each handshake.
module tb_data_write_buffer;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        up_req = 1'b0;
    logic        up_wr = 1'b0;
    logic [1:0]  up_size = 2'd0;
    logic [31:0] up_addr = '0;
    logic [31:0] up_wdata = '0;
    logic [31:0] up_rdata;
    logic        up_addr_ok, up_data_ok;
    logic        dn_req, dn_wr;
    logic [1:0]  dn_size;
    logic [31:0] dn_addr, dn_wdata;
    logic [31:0] dn_rdata;
    logic        dn_addr_ok, dn_data_ok;
    logic        wb_empty;

    logic        addr_ready = 1'b1;
    logic        data_ready = 1'b1;
    logic        pending;
    logic [31:0] rdata_drv = '0;
    int          done_cnt;

    int   checks = 0;
    int   errors = 0;
    txn_t exp_q[$];
    txn_t mon_t;

    data_write_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .up_req     (up_req),
        .up_wr      (up_wr),
        .up_size    (up_size),
        .up_addr    (up_addr),
        .up_wdata   (up_wdata),
        .up_rdata   (up_rdata),
        .up_addr_ok (up_addr_ok),
        .up_data_ok (up_data_ok),
        .dn_req     (dn_req),
        .dn_wr      (dn_wr),
        .dn_size    (dn_size),
        .dn_addr    (dn_addr),
        .dn_wdata   (dn_wdata),
        .dn_rdata   (dn_rdata),
        .dn_addr_ok (dn_addr_ok),
        .dn_data_ok (dn_data_ok),
        .wb_empty   (wb_empty)
    );

    always #5 clk = ~clk;

    // Downstream slave: accepts addresses when addr_ready, completes when data_ready.
    assign dn_addr_ok = dn_req & addr_ready;
    assign dn_data_ok = pending & data_ready;
    assign dn_rdata   = rdata_drv;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending  <= 1'b0;
            done_cnt <= 0;
        end else begin
            if (dn_req && dn_addr_ok) pending <= 1'b1;
            else if (dn_data_ok)      pending <= 1'b0;
            if (dn_data_ok) done_cnt <= done_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (resetn && dn_req && dn_addr_ok) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL dn_unexpected got addr=%h wr=%0b exp no transaction", dn_addr, dn_wr);
            end else begin
                mon_t = exp_q.pop_front();
                if ({dn_wr, dn_addr, dn_size, dn_wdata} !== mon_t) begin
                    errors++;
                    $display("[TB] FAIL dn_txn got wr=%0b addr=%h size=%0d wdata=%h exp wr=%0b addr=%h size=%0d wdata=%h",
                             dn_wr, dn_addr, dn_size, dn_wdata, mon_t.wr, mon_t.addr, mon_t.size, mon_t.wdata);
                end
            end
        end
    end

    task automatic drive_write(input string name, input logic [31:0] a, input logic [1:0] s,
                               input logic [31:0] d, input logic exp_ok);
        up_req = 1'b1; up_wr = 1'b1; up_addr = a; up_size = s; up_wdata = d;
        @(negedge clk);
        checks++;
        if (up_addr_ok !== exp_ok) begin
            errors++;
            $display("[TB] FAIL %s up_addr_ok got %0b exp %0b", name, up_addr_ok, exp_ok);
        end
        if (up_addr_ok) exp_q.push_back({1'b1, a, s, d});
        @(posedge clk); #1;
        up_req = 1'b0;
    endtask

    task automatic write_retry(input string name, input logic [31:0] a, input logic [1:0] s,
                               input logic [31:0] d);
        bit accepted = 0;
        up_req = 1'b1; up_wr = 1'b1; up_addr = a; up_size = s; up_wdata = d;
        for (int k = 0; k < 50 && !accepted; k++) begin
            @(negedge clk);
            if (up_addr_ok) begin
                accepted = 1;
                exp_q.push_back({1'b1, a, s, d});
            end
            @(posedge clk); #1;
        end
        up_req = 1'b0;
        checks++;
        if (!accepted) begin
            errors++;
            $display("[TB] FAIL %s accept_timeout got 0 exp 1", name);
        end
    endtask

    task automatic wait_empty(input string name);
        for (int k = 0; k < 100 && !wb_empty; k++) @(negedge clk);
        checks++;
        if (wb_empty !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s drain got wb_empty=%0b pending=%0d exp wb_empty=1 pending=0",
                     name, wb_empty, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({dn_req, dn_wr, dn_size, dn_addr, dn_wdata} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_dn got req=%0b wr=%0b size=%0d addr=%h wdata=%h exp all 0",
                     dn_req, dn_wr, dn_size, dn_addr, dn_wdata);
        end
        checks++;
        if ({up_addr_ok, up_data_ok, up_rdata} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_up got addr_ok=%0b data_ok=%0b rdata=%h exp 0", up_addr_ok, up_data_ok, up_rdata);
        end
        checks++;
        if (wb_empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_empty got %0b exp 1", wb_empty);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_write();
        addr_ready = 1'b1; data_ready = 1'b1;
        drive_write("single_accept", 32'h0000_1010, 2'd2, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        checks++;
        if (up_data_ok !== 1'b1 || dn_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_ack got data_ok=%0b dn_req=%0b exp 1 0", up_data_ok, dn_req);
        end
        @(negedge clk);
        checks++;
        if (dn_req !== 1'b1 || up_data_ok !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_dn_req got dn_req=%0b data_ok=%0b exp 1 0", dn_req, up_data_ok);
        end
        @(posedge clk); #1;
        wait_empty("single");
    endtask

    task automatic test_back_to_back();
        int  base;
        bit  accepted = 0;
        addr_ready = 1'b0; data_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            drive_write("b2b_fill", 32'(i * 4), 2'd2, 32'hA000_0000 + 32'(i), 1'b1);
        up_req = 1'b1; up_wr = 1'b1; up_addr = 32'h10; up_size = 2'd2; up_wdata = 32'hA000_0004;
        @(negedge clk);
        checks++;
        if (up_addr_ok !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_full got %0b exp 0", up_addr_ok);
        end
        base = done_cnt;
        addr_ready = 1'b1;
        for (int k = 0; k < 30 && !accepted; k++) begin
            @(negedge clk);
            if (up_addr_ok) accepted = 1;
        end
        checks++;
        if (!accepted || (done_cnt - base) < 1) begin
            errors++;
            $display("[TB] FAIL b2b_fifth got accepted=%0b pops=%0d exp accepted=1 pops>=1",
                     accepted, done_cnt - base);
        end
        if (accepted) exp_q.push_back({1'b1, 32'h10, 2'd2, 32'hA000_0004});
        @(posedge clk); #1;
        up_req = 1'b0;
        wait_empty("b2b");
    endtask

    task automatic test_read_after_write();
        int base;
        bit accepted = 0;
        bit seen = 0;
        addr_ready = 1'b1; data_ready = 1'b1;
        rdata_drv = 32'h1234_5678;
        base = done_cnt;
        drive_write("raw_w0", 32'h100, 2'd2, 32'h1111_0000, 1'b1);
        drive_write("raw_w1", 32'h104, 2'd2, 32'h1111_0001, 1'b1);
        up_req = 1'b1; up_wr = 1'b0; up_addr = 32'h2000; up_size = 2'd2; up_wdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 40 && !accepted; k++) begin
            @(negedge clk);
            if (up_addr_ok) accepted = 1;
        end
        checks++;
        if (!accepted || (done_cnt - base) != 2) begin
            errors++;
            $display("[TB] FAIL raw_read_order got accepted=%0b writes_done=%0d exp 1 2", accepted, done_cnt - base);
        end
        if (accepted) exp_q.push_back({1'b0, 32'h2000, 2'd2, 32'h0});
        @(posedge clk); #1;
        up_req = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (dn_data_ok) seen = 1;
        end
        checks++;
        if (!seen || up_data_ok !== 1'b1 || up_rdata !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL raw_rdata got seen=%0b data_ok=%0b rdata=%h exp 1 1 12345678", seen, up_data_ok, up_rdata);
        end
        @(posedge clk); #1;
        wait_empty("raw");
    endtask

    task automatic test_push_pop_same_cycle();
        addr_ready = 1'b0; data_ready = 1'b1;
        drive_write("pp_a", 32'h200, 2'd2, 32'hC000_0000, 1'b1);
        drive_write("pp_b", 32'h204, 2'd2, 32'hC000_0001, 1'b1);
        addr_ready = 1'b1;
        @(posedge clk); #1;
        drive_write("pp_c_with_pop", 32'h208, 2'd2, 32'hC000_0002, 1'b1);
        addr_ready = 1'b0;
        drive_write("pp_d", 32'h20C, 2'd2, 32'hC000_0003, 1'b1);
        drive_write("pp_e", 32'h210, 2'd2, 32'hC000_0004, 1'b1);
        drive_write("pp_f_full", 32'h214, 2'd2, 32'hC000_0005, 1'b0);
        addr_ready = 1'b1;
        wait_empty("pp");
        for (int i = 0; i < 8; i++)
            write_retry("wrap", 32'h4000 + 32'(i * 4), 2'd2, $urandom);
        wait_empty("wrap");
    endtask

    task automatic test_byte_store();
        addr_ready = 1'b1; data_ready = 1'b1;
        write_retry("byte", 32'h0000_3003, 2'd0, 32'h0000_00AB);
        wait_empty("byte");
    endtask

    task automatic test_reset_mid();
        addr_ready = 1'b0; data_ready = 1'b0;
        write_retry("rst_w0", 32'h500, 2'd2, 32'hE000_0000);
        write_retry("rst_w1", 32'h504, 2'd2, 32'hE000_0001);
        write_retry("rst_w2", 32'h508, 2'd2, 32'hE000_0002);
        addr_ready = 1'b1;
        @(posedge clk); #1;
        addr_ready = 1'b0;
        resetn = 1'b0;
        #1;
        checks++;
        if (dn_req !== 1'b0 || wb_empty !== 1'b1 || up_data_ok !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid got dn_req=%0b wb_empty=%0b data_ok=%0b exp 0 1 0", dn_req, wb_empty, up_data_ok);
        end
        exp_q.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        addr_ready = 1'b1; data_ready = 1'b1;
        @(posedge clk); #1;
        write_retry("rst_after", 32'h5000, 2'd2, 32'h0BAD_F00D);
        wait_empty("rst_after");
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_read_after_write();
        test_push_pop_same_cycle();
        test_byte_store();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout exp completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
